// File: rtl/comparador_sequencial.sv
// Registered unsigned comparator with a mode-selected relation, a run-length
// lock detector (IDLE/COUNT/LOCKED) and a saturating total-hit counter.
`timescale 1ns/1ps
module comparador_sequencial #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned N_MATCH = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             VALID_IN,
    input  logic [1:0]       MODE,
    input  logic             CLR,
    output logic             X,
    output logic             EQ,
    output logic             GT,
    output logic             LT,
    output logic             VALID_OUT,
    output logic             LOCK,
    output logic [CNT_W-1:0] HITS
);

    localparam int unsigned      RUN_W    = $clog2(N_MATCH + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(N_MATCH);
    localparam logic [CNT_W-1:0] HITS_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_LOCKED
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
    logic [CNT_W-1:0] r_hits, w_hits_nxt;
    logic             r_lock;
    logic             r_x, r_eq, r_gt, r_lt, r_valid_out;
    logic             w_eq, w_gt, w_lt, w_rel;

    assign w_eq      = (A == B);
    assign w_gt      = (A > B);
    assign w_lt      = (A < B);
    assign w_run_inc = r_run + RUN_W'(1);

    // Relation chosen by the mode sampled alongside the operands
    always_comb begin
        w_rel = 1'b0;
        case (MODE)
            2'b00:   w_rel = w_eq;
            2'b01:   w_rel = w_gt;
            2'b10:   w_rel = w_lt;
            default: w_rel = w_gt | w_eq;
        endcase
    end

    // Next-state: CLR dominates, a miss restarts the run, LOCKED saturates
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_hits_nxt  = r_hits;
        if (CLR) begin
            w_state_nxt = S_IDLE;
            w_run_nxt   = '0;
            w_hits_nxt  = '0;
        end else if (VALID_IN) begin
            if (w_rel) begin
                if (r_hits != HITS_MAX) begin
                    w_hits_nxt = r_hits + CNT_W'(1);
                end
                if (r_state != S_LOCKED) begin
                    w_run_nxt   = w_run_inc;
                    w_state_nxt = (w_run_inc == RUN_MAX) ? S_LOCKED : S_COUNT;
                end
            end else begin
                w_state_nxt = S_IDLE;
                w_run_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_run   <= '0;
            r_hits  <= '0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_hits  <= w_hits_nxt;
            r_lock  <= (w_state_nxt == S_LOCKED);
        end
    end

    // Result flags update only on valid samples and hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= VALID_IN;
            if (VALID_IN) begin
                r_x  <= w_rel;
                r_eq <= w_eq;
                r_gt <= w_gt;
                r_lt <= w_lt;
            end
        end
    end

    assign X         = r_x;
    assign EQ        = r_eq;
    assign GT        = r_gt;
    assign LT        = r_lt;
    assign VALID_OUT = r_valid_out;
    assign LOCK      = r_lock;
    assign HITS      = r_hits;

endmodule

// File: tb/tb_comparador_sequencial.sv
// Directed bench for comparador_sequencial: per-sample expected results are
// queued at drive time and popped when VALID_OUT strobes.
`timescale 1ns/1ps
module tb_comparador_sequencial;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned N_MATCH = 3;
    localparam int unsigned CNT_W   = 4;

    typedef struct packed {
        logic x;
        logic eq;
        logic gt;
        logic lt;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] A, B;
    logic             VALID_IN, CLR;
    logic [1:0]       MODE;
    logic             X, EQ, GT, LT, VALID_OUT, LOCK;
    logic [CNT_W-1:0] HITS;

    res_t q[$];
    res_t last;
    int   m_run;
    int   m_hits;
    int   n_tests = 0;
    int   n_fail  = 0;

    comparador_sequencial #(.WIDTH(WIDTH), .N_MATCH(N_MATCH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .VALID_IN(VALID_IN), .MODE(MODE),
        .CLR(CLR), .X(X), .EQ(EQ), .GT(GT), .LT(LT), .VALID_OUT(VALID_OUT),
        .LOCK(LOCK), .HITS(HITS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, 32'(X), 0);
        chk({tag, "_eq"}, 32'(EQ), 0);
        chk({tag, "_gt"}, 32'(GT), 0);
        chk({tag, "_lt"}, 32'(LT), 0);
        chk({tag, "_vout"}, 32'(VALID_OUT), 0);
        chk({tag, "_lock"}, 32'(LOCK), 0);
        chk({tag, "_hits"}, 32'(HITS), 0);
    endtask

    // One clock: drive on falling edge, sample 1ns after the rising edge
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        input logic v, input logic c);
        res_t e, got;
        @(negedge clk);
        A = a; B = b; MODE = m; VALID_IN = v; CLR = c;
        e.eq = (a == b);
        e.gt = (a > b);
        e.lt = (a < b);
        case (m)
            2'b00:   e.x = e.eq;
            2'b01:   e.x = e.gt;
            2'b10:   e.x = e.lt;
            default: e.x = e.gt | e.eq;
        endcase
        if (c) begin
            m_run  = 0;
            m_hits = 0;
        end else if (v) begin
            if (e.x) begin
                if (m_hits != 15) m_hits++;
                if (m_run < int'(N_MATCH)) m_run++;
            end else begin
                m_run = 0;
            end
        end
        if (v) q.push_back(e);
        @(posedge clk);
        #1;
        chk("valid_out", 32'(VALID_OUT), 32'(v));
        got = last;
        if (VALID_OUT === 1'b1) begin
            chk("queue_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) got = q.pop_front();
        end
        chk("x", 32'(X), 32'(got.x));
        chk("eq", 32'(EQ), 32'(got.eq));
        chk("gt", 32'(GT), 32'(got.gt));
        chk("lt", 32'(LT), 32'(got.lt));
        chk("lock", 32'(LOCK), 32'(m_run == int'(N_MATCH)));
        chk("hits", 32'(HITS), 32'(m_hits));
        last = got;
    endtask

    // Reset pulse placed between clock edges
    task automatic rst_pulse();
        @(negedge clk);
        VALID_IN = 1'b0; CLR = 1'b0;
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        #1 rst = 1'b0;
        m_run  = 0;
        m_hits = 0;
        last   = '0;
        #1 chk_all_zero("after_rst_release");
    endtask

    initial begin
        rst = 1'b1; A = '0; B = '0; MODE = 2'b00; VALID_IN = 1'b0; CLR = 1'b0;
        m_run = 0; m_hits = 0; last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_all_zero("reset_state");

        // Three equal samples lock, then a miss unlocks
        repeat (3) step(8'hA5, 8'hA5, 2'b00, 1'b1, 1'b0);
        chk("lock_after_3_eq", 32'(LOCK), 1);
        chk("hits_after_3_eq", 32'(HITS), 3);
        step(8'h10, 8'h11, 2'b00, 1'b1, 1'b0);
        chk("lt_on_miss", 32'(LT), 1);
        chk("lock_drop_on_miss", 32'(LOCK), 0);
        chk("hits_hold_on_miss", 32'(HITS), 3);

        // Unsigned relations under each mode
        step(8'h80, 8'h7F, 2'b01, 1'b1, 1'b0);
        chk("gt_unsigned", 32'(GT), 1);
        step(8'h00, 8'h00, 2'b11, 1'b1, 1'b0);
        chk("ge_on_equal", 32'(X), 1);
        step(8'hFF, 8'h00, 2'b10, 1'b1, 1'b0);
        chk("lt_mode_false", 32'(X), 0);
        chk("lt_mode_gt_flag", 32'(GT), 1);

        // Idle gaps neither break nor advance a run
        step(8'h01, 8'h01, 2'b00, 1'b1, 1'b0);
        repeat (5) step(8'h33, 8'h44, 2'b01, 1'b0, 1'b0);
        step(8'h02, 8'h02, 2'b00, 1'b1, 1'b0);
        chk("no_lock_before_3rd", 32'(LOCK), 0);
        step(8'h03, 8'h03, 2'b00, 1'b1, 1'b0);
        chk("lock_across_gaps", 32'(LOCK), 1);

        // Saturation of HITS, then CLR racing a valid hit
        for (int i = 0; i < 20; i++) step(8'(i + 8), 8'(i), 2'b01, 1'b1, 1'b0);
        chk("hits_saturated", 32'(HITS), 15);
        chk("lock_held_sat", 32'(LOCK), 1);
        step(8'h05, 8'h05, 2'b00, 1'b1, 1'b1);
        chk("clr_hits", 32'(HITS), 0);
        chk("clr_lock", 32'(LOCK), 0);
        chk("clr_vout", 32'(VALID_OUT), 1);
        chk("clr_x", 32'(X), 1);

        // CLR without a sample keeps flags
        step(8'h09, 8'h09, 2'b00, 1'b1, 1'b0);
        step(8'h00, 8'h01, 2'b00, 1'b0, 1'b1);
        chk("clr_idle_hits", 32'(HITS), 0);

        // Reset mid-run discards the run
        step(8'h20, 8'h10, 2'b11, 1'b1, 1'b0);
        step(8'h20, 8'h20, 2'b11, 1'b1, 1'b0);
        rst_pulse();
        step(8'h07, 8'h08, 2'b10, 1'b1, 1'b0);
        step(8'h07, 8'h08, 2'b10, 1'b1, 1'b0);
        chk("post_rst_lock_low", 32'(LOCK), 0);
        chk("post_rst_hits", 32'(HITS), 2);
        step(8'h07, 8'h08, 2'b10, 1'b1, 1'b0);
        chk("post_rst_lock", 32'(LOCK), 1);

        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comparador_sequencial.md
COMPARADOR_SEQUENCIAL -- requirements
Module: comparador_sequencial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (>=1).
REQ-002 SHALL have parameter N_MATCH, default 4, consecutive valid hits needed to assert LOCK (>=1).
REQ-003 SHALL have parameter CNT_W, default 8, width of hit counter HITS (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port A  input  WIDTH  unsigned operand A.
REQ-007 SHALL have port B  input  WIDTH  unsigned operand B.
REQ-008 SHALL have port VALID_IN  input  1  A, B, MODE hold a sample this cycle.
REQ-009 SHALL have port MODE  input  2  selected relation: 00 A==B, 01 A>B, 10 A<B, 11 A>=B.
REQ-010 SHALL have port CLR  input  1  synchronous clear of HITS and lock state.
REQ-011 SHALL have port X  output  1  registered result of the MODE-selected relation.
REQ-012 SHALL have ports EQ, GT, LT  output  1 each  registered A==B, A>B, A<B flags.
REQ-013 SHALL have port VALID_OUT  output  1  one-cycle strobe: X/EQ/GT/LT hold a new result.
REQ-014 SHALL have port LOCK  output  1  N_MATCH consecutive valid hits seen.
REQ-015 SHALL have port HITS  output  CNT_W  saturating total of valid hits.
REQ-016 The design SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-017 Comparison SHALL be unsigned over the full WIDTH bits; exactly one of EQ, GT, LT SHALL be 1 after the first valid sample.
REQ-018 Latency SHALL be 1 cycle: sample at edge k -> X/EQ/GT/LT/VALID_OUT updated after edge k, visible in cycle k+1.
REQ-019 VALID_OUT SHALL be 1 only in the cycle after a VALID_IN=1 edge; otherwise 0.
REQ-020 With VALID_IN=0, X/EQ/GT/LT SHALL hold their last values; no counters change.
REQ-021 MODE SHALL be sampled at the same edge as A and B; a MODE change applies only to samples taken with it.
REQ-022 A hit SHALL be a valid sample whose MODE-selected relation is true; a miss a valid sample where it is false.
REQ-023 An internal run counter (0..N_MATCH) SHALL drive FSM states IDLE (run=0), COUNT (0<run<N_MATCH), LOCKED (run=N_MATCH).
REQ-024 Hit: IDLE->COUNT (or ->LOCKED if N_MATCH=1), COUNT->COUNT with run+1 or ->LOCKED when run+1=N_MATCH, LOCKED stays LOCKED (run saturates).
REQ-025 Miss in any state SHALL go to IDLE with run=0.
REQ-026 Cycles with VALID_IN=0 SHALL NOT break or advance a run.
REQ-027 LOCK SHALL equal (state==LOCKED) and SHALL rise in the same cycle as the VALID_OUT of the N_MATCH-th consecutive hit.
REQ-028 HITS SHALL increment by 1 per hit and saturate at 2^CNT_W-1 without wrap.
REQ-029 CLR=1 at an edge SHALL set HITS=0, run=0, state IDLE, LOCK=0 after that edge.
REQ-030 CLR and VALID_IN both 1: CLR SHALL win for HITS/run/LOCK (sample not counted); X/EQ/GT/LT/VALID_OUT SHALL still update from the sample.

Reset
REQ-031 rst=1 SHALL immediately, independent of clk, force X=0, EQ=0, GT=0, LT=0, VALID_OUT=0, LOCK=0, HITS=0, run=0, state IDLE.
REQ-032 Reset asserted mid-run SHALL discard the run; first valid sample after release SHALL be treated as run start.

Verification (WIDTH=8, N_MATCH=3, CNT_W=4)
REQ-033 Async reset: pulse rst between clock edges -> all outputs 0 before next edge.
REQ-034 MODE=00, A=B=0xA5 valid 3 consecutive cycles -> X=1, EQ=1 each result; LOCK=1 with 3rd VALID_OUT; HITS=3; then A=0x10,B=0x11 valid -> X=0, LT=1, LOCK=0, HITS=3.
REQ-035 MODE=01, A=0x80,B=0x7F -> GT=1, X=1 (unsigned); MODE=11, A=B=0x00 -> EQ=1, X=1; MODE=10, A=0xFF,B=0x00 -> GT=1, X=0.
REQ-036 Gaps: hit, VALID_IN=0 for 5 cycles (VALID_OUT=0, flags hold), hit, hit -> LOCK=1 on 3rd hit result.
REQ-037 20 consecutive hits -> HITS stops at 15, LOCK stays 1; then CLR=1 with a valid hit -> HITS=0, LOCK=0, VALID_OUT=1, X=1.
REQ-038 Two hits then rst pulse, release, two hits -> LOCK=0, HITS=2; third hit -> LOCK=1.
